// File: rtl/udma_tx_l2_rd_arbiter_if.sv
// uDMA Tx L2 read arbiter bundle: channel-side request/return
// signals and the L2 master read port.
interface udma_tx_l2_rd_arbiter_if #(
    parameter int N_CH = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [N_CH-1:0]    ch_req_i;
    logic [N_CH*AW-1:0] ch_addr_i;
    logic [N_CH-1:0]    ch_gnt_o;
    logic [N_CH-1:0]    ch_rvalid_o;
    logic [DW-1:0]      ch_rdata_o;
    logic               l2_req_o;
    logic [AW-1:0]      l2_addr_o;
    logic               l2_gnt_i;
    logic               l2_rvalid_i;
    logic [DW-1:0]      l2_rdata_i;
    logic               busy_o;
    logic               err_o;

    // Arbiter side
    modport master (
        input  ch_req_i,
        input  ch_addr_i,
        output ch_gnt_o,
        output ch_rvalid_o,
        output ch_rdata_o,
        output l2_req_o,
        output l2_addr_o,
        input  l2_gnt_i,
        input  l2_rvalid_i,
        input  l2_rdata_i,
        output busy_o,
        output err_o
    );

    // Channels + L2 side
    modport slave (
        output ch_req_i,
        output ch_addr_i,
        input  ch_gnt_o,
        input  ch_rvalid_o,
        input  ch_rdata_o,
        input  l2_req_o,
        input  l2_addr_o,
        output l2_gnt_i,
        output l2_rvalid_i,
        output l2_rdata_i,
        input  busy_o,
        input  err_o
    );
endinterface

// File: rtl/udma_tx_l2_rd_arbiter.sv
// uDMA Tx L2 read arbiter: round-robin over N_CH channels, in-order
// ID FIFO routes read data back. Option: UDMA_TX_L2_ARB_PRIO0_EN.
module udma_tx_l2_rd_arbiter #(
    parameter int N_CH   = 4,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int OUTSTD = 4
) (
    input logic clk_i,
    input logic rst_i,
    udma_tx_l2_rd_arbiter_if.master bus
);

    localparam int IW = $clog2(N_CH);
    localparam int KW = IW + 1;
    localparam int PW = $clog2(OUTSTD);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_id;
    logic [IW-1:0]   w_id_nxt;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   w_rr_nxt;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   w_addr_nxt;

    logic [N_CH-1:0] w_req_m;
    logic [KW-1:0]   w_k;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [AW-1:0]   w_win_addr;

    logic [IW-1:0]   r_fifo [OUTSTD];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [IW-1:0]   w_head;

    logic [N_CH-1:0] w_gnt;
    logic [N_CH-1:0] w_rvalid;

    assign w_full  = (r_cnt == CW'(OUTSTD));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[r_rd];
    assign w_pop   = bus.l2_rvalid_i & ~w_empty;

    // Winner search: first requester at or after the rr pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_k     = '0;
        w_req_m = bus.ch_req_i;
`ifdef UDMA_TX_L2_ARB_PRIO0_EN
        w_req_m[0] = 1'b0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            w_k = {1'b0, r_rr} + KW'(i);
            if (w_k >= KW'(N_CH)) begin
                w_k = w_k - KW'(N_CH);
            end
            if (!w_found && w_req_m[w_k[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_k[IW-1:0];
            end
        end
`ifdef UDMA_TX_L2_ARB_PRIO0_EN
        if (bus.ch_req_i[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
`endif
    end

    // Address mux for the winning channel
    always_comb begin
        w_win_addr = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (IW'(c) == w_win) begin
                w_win_addr = bus.ch_addr_i[c*AW +: AW];
            end
        end
    end

    // FSM next state, latch and rr update
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_addr_nxt  = r_addr;
        w_rr_nxt    = r_rr;
        w_push      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found && !w_full) begin
                    w_state_nxt = S_REQ;
                    w_id_nxt    = w_win;
                    w_addr_nxt  = w_win_addr;
                end
            end
            S_REQ: begin
                if (bus.l2_gnt_i) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                    if (r_id == IW'(N_CH - 1)) begin
                        w_rr_nxt = '0;
                    end else begin
                        w_rr_nxt = r_id + IW'(1);
                    end
`ifdef UDMA_TX_L2_ARB_PRIO0_EN
                    // Strict-priority channel 0 leaves the rr order alone
                    if (r_id == '0) begin
                        w_rr_nxt = r_rr;
                    end
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM and request latch registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_rr    <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
            r_rr    <= w_rr_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // ID FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr] <= r_id;
        end
    end

    // ID FIFO pointers, occupancy and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (bus.l2_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // One-hot grant and return-valid decode
    always_comb begin
        w_gnt          = '0;
        w_rvalid       = '0;
        w_gnt[r_id]    = w_push;
        w_rvalid[w_head] = w_pop;
    end

    assign bus.ch_gnt_o    = w_gnt;
    assign bus.ch_rvalid_o = w_rvalid;
    assign bus.ch_rdata_o  = bus.l2_rdata_i;
    assign bus.l2_req_o    = (r_state == S_REQ);
    assign bus.l2_addr_o   = (r_state == S_REQ) ? r_addr : '0;
    assign bus.busy_o      = (r_state == S_REQ) | ~w_empty;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_udma_tx_l2_rd_arbiter.sv
// Testbench for udma_tx_l2_rd_arbiter: directed steps with grant and
// read-return scoreboards.
module tb_udma_tx_l2_rd_arbiter;

`ifdef UDMA_TX_L2_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   q_gnt[$];
    int   q_ret_ch[$];
    logic [31:0] q_ret_d[$];

    udma_tx_l2_rd_arbiter_if #(.N_CH(4), .AW(32), .DW(32)) bus ();

    udma_tx_l2_rd_arbiter #(
        .N_CH  (4),
        .AW    (32),
        .DW    (32),
        .OUTSTD(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.ch_req_i    = '0;
        bus.ch_addr_i   = '0;
        bus.l2_gnt_i    = 1'b0;
        bus.l2_rvalid_i = 1'b0;
        bus.l2_rdata_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic ret_check(input string tag);
        int ch;
        logic [31:0] d;
        chk({tag, "_q"}, 64'(q_ret_ch.size() != 0), 64'd1);
        if (q_ret_ch.size() != 0) begin
            ch = q_ret_ch.pop_front();
            d  = q_ret_d.pop_front();
            chk({tag, "_rvalid"}, 64'(bus.ch_rvalid_o), 64'(1) << ch);
            chk({tag, "_rdata"}, 64'(bus.ch_rdata_o), 64'(d));
        end
    endtask

    // Runs until n grants seen; each is checked against q_gnt and the
    // spacing to the previous grant. Optionally returns read data one
    // cycle after each grant. nreq is applied right after the last grant.
    task automatic run_grants(input int n, input bit ret,
                              input logic [3:0] nreq);
        int got;
        int last;
        int cyc;
        int e;
        bit pend;
        logic [31:0] d;
        got  = 0;
        last = -1;
        cyc  = 0;
        pend = 1'b0;
        d    = '0;
        while (got < n && cyc < 80) begin
            @(negedge clk);
            if (bus.l2_rvalid_i) begin
                ret_check("rr_ret");
            end
            pend = 1'b0;
            if (|bus.ch_gnt_o) begin
                e = (q_gnt.size() != 0) ? q_gnt.pop_front() : -1;
                chk("gnt_order", 64'(bus.ch_gnt_o), 64'(1) << e);
                if (last >= 0) begin
                    chk("gnt_gap", 64'(cyc - last), 64'd2);
                end
                last = cyc;
                got++;
                if (ret) begin
                    d = 32'hA500_0000 + 32'(cyc);
                    q_ret_ch.push_back(e);
                    q_ret_d.push_back(d);
                    pend = 1'b1;
                end
            end
            tick();
            cyc++;
            bus.l2_rvalid_i = pend;
            bus.l2_rdata_i  = d;
            if (got == n) begin
                bus.ch_req_i = nreq;
            end
        end
        chk("gnt_count", 64'(got), 64'(n));
        if (pend) begin
            @(negedge clk);
            ret_check("rr_last_ret");
            tick();
        end
        bus.l2_rvalid_i = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clr_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_l2_req", 64'(bus.l2_req_o), 64'd0);
        chk("rst_gnt", 64'(bus.ch_gnt_o), 64'd0);
        chk("rst_rvalid", 64'(bus.ch_rvalid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        tick();

        // Single request on channel 2
        bus.ch_req_i            = 4'b0100;
        bus.ch_addr_i[2*32 +: 32] = 32'h1C00_0040;
        @(negedge clk);
        chk("lat_idle", 64'(bus.l2_req_o), 64'd0);
        tick();
        @(negedge clk);
        chk("single_req", 64'(bus.l2_req_o), 64'd1);
        chk("single_addr", 64'(bus.l2_addr_o), 64'h1C00_0040);
        tick();
        bus.l2_gnt_i = 1'b1;
        @(negedge clk);
        chk("single_gnt", 64'(bus.ch_gnt_o), 64'b0100);
        chk("single_addr2", 64'(bus.l2_addr_o), 64'h1C00_0040);
        q_ret_ch.push_back(2);
        q_ret_d.push_back(32'hDEAD_BEEF);
        tick();
        bus.l2_gnt_i = 1'b0;
        bus.ch_req_i = '0;
        tick();
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        ret_check("single_ret");
        tick();
        bus.l2_rvalid_i = 1'b0;
        @(negedge clk);
        chk("single_busy_end", 64'(bus.busy_o), 64'd0);
        tick();

        // Round robin, all channels requesting
        do_reset();
        for (int i = 0; i < 6; i++) begin
            q_gnt.push_back(PRIO ? 0 : i % 4);
        end
        bus.ch_req_i = 4'b1111;
        bus.l2_gnt_i = 1'b1;
        run_grants(6, 1'b1, 4'b0000);
        bus.l2_gnt_i = 1'b0;
        @(negedge clk);
        chk("rr_idle_busy", 64'(bus.busy_o), 64'd0);
        tick();

        // Outstanding limit
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_gnt.push_back(PRIO ? 0 : i);
        end
        bus.ch_req_i = 4'b1111;
        bus.l2_gnt_i = 1'b1;
        run_grants(4, 1'b0, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_no_req", 64'(bus.l2_req_o), 64'd0);
            chk("full_busy", 64'(bus.busy_o), 64'd1);
            tick();
        end
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'h55AA_0001;
        q_ret_ch.push_back(0);
        q_ret_d.push_back(32'h55AA_0001);
        @(negedge clk);
        ret_check("full_ret");
        chk("full_pop_cycle", 64'(bus.l2_req_o), 64'd0);
        tick();
        bus.l2_rvalid_i = 1'b0;
        @(negedge clk);
        chk("full_arb_cycle", 64'(bus.l2_req_o), 64'd0);
        tick();
        @(negedge clk);
        chk("fifth_req", 64'(bus.l2_req_o), 64'd1);
        chk("fifth_gnt", 64'(bus.ch_gnt_o), 64'b0001);
        tick();
        bus.ch_req_i = '0;
        bus.l2_gnt_i = 1'b0;

        // Stall in REQ with changing requests
        do_reset();
        bus.ch_req_i              = 4'b0010;
        bus.ch_addr_i[1*32 +: 32] = 32'h1000_0010;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.ch_req_i  = 4'($urandom);
            bus.ch_addr_i = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stall_req", 64'(bus.l2_req_o), 64'd1);
            chk("stall_addr", 64'(bus.l2_addr_o), 64'h1000_0010);
            tick();
        end
        bus.ch_req_i = 4'b1111;
        bus.l2_gnt_i = 1'b1;
        @(negedge clk);
        chk("stall_gnt", 64'(bus.ch_gnt_o), 64'b0010);
        tick();
        bus.ch_req_i = '0;
        bus.l2_gnt_i = 1'b0;

        // Error on return with empty FIFO, then reset with reads in flight
        do_reset();
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'h0000_1234;
        @(negedge clk);
        chk("err_no_rvalid", 64'(bus.ch_rvalid_o), 64'd0);
        chk("err_not_yet", 64'(bus.err_o), 64'd0);
        tick();
        bus.l2_rvalid_i = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(bus.err_o), 64'd1);
        tick();
        q_gnt.push_back(0);
        q_gnt.push_back(0);
        bus.ch_req_i = 4'b0001;
        bus.l2_gnt_i = 1'b1;
        run_grants(2, 1'b0, 4'b0000);
        bus.l2_gnt_i = 1'b0;
        @(negedge clk);
        chk("outstd_busy", 64'(bus.busy_o), 64'd1);
        chk("err_sticky", 64'(bus.err_o), 64'd1);
        tick();
        do_reset();
        @(negedge clk);
        chk("mid_rst_req", 64'(bus.l2_req_o), 64'd0);
        chk("mid_rst_gnt", 64'(bus.ch_gnt_o), 64'd0);
        chk("mid_rst_rvalid", 64'(bus.ch_rvalid_o), 64'd0);
        chk("mid_rst_rdata", 64'(bus.ch_rdata_o), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        chk("mid_rst_err", 64'(bus.err_o), 64'd0);
        tick();
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = 32'h0000_CAFE;
        @(negedge clk);
        chk("inflight_no_rvalid", 64'(bus.ch_rvalid_o), 64'd0);
        tick();
        bus.l2_rvalid_i = 1'b0;
        @(negedge clk);
        chk("inflight_err", 64'(bus.err_o), 64'd1);
        tick();

`ifdef UDMA_TX_L2_ARB_PRIO0_EN
        // Channel 0 strict priority over channel 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_gnt.push_back(0);
        end
        bus.ch_req_i = 4'b0101;
        bus.l2_gnt_i = 1'b1;
        run_grants(4, 1'b1, 4'b0100);
        q_gnt.push_back(2);
        run_grants(1, 1'b1, 4'b0000);
        bus.l2_gnt_i = 1'b0;
        tick();
`endif

        chk("gnt_queue_empty", 64'(q_gnt.size()), 64'd0);
        chk("ret_queue_empty", 64'(q_ret_ch.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_tx_l2_rd_arbiter.md
Name: udma_tx_l2_rd_arbiter

Overview:
Shares the single L2 read port between the N uDMA Tx channels.
- Round-robin arbitration of per-channel read requests.
- Holds the winning request stable on L2 until accepted.
- Tracks outstanding reads in an in-order ID FIFO and routes each returned read word back to the requesting channel.
- Sits between the Tx channel control-plane logic and the L2 interconnect master port.

Parameters:
- N_CH, 4, number of Tx channels (2..16).
- AW, 32, L2 address width.
- DW, 32, L2 data width.
- OUTSTD, 4, max outstanding L2 reads (power of 2, 2..16).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- ch_req_i  in  N_CH  per-channel read request; level, held until granted.
- ch_addr_i  in  N_CH*AW  per-channel read address; channel c at [c*AW +: AW].
- ch_gnt_o  out  N_CH  one-hot, 1-cycle pulse: request of channel c accepted by L2.
- ch_rvalid_o  out  N_CH  one-hot read-data valid to channel.
- ch_rdata_o  out  DW  read data, shared by all channels; qualified by ch_rvalid_o.
- l2_req_o  out  1  L2 read request.
- l2_addr_o  out  AW  L2 read address.
- l2_gnt_i  in  1  L2 accepts request this cycle.
- l2_rvalid_i  in  1  L2 read data valid; in-order.
- l2_rdata_i  in  DW  L2 read data.
- busy_o  out  1  request pending or reads outstanding.
- err_o  out  1  sticky: l2_rvalid_i seen with no outstanding read.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; rr pointer=0; ID FIFO empty, count=0; err_o=0.
- Reset mid-operation: pending request dropped, FIFO flushed; in-flight L2 data arriving after reset sets err_o.
- FSM IDLE:
  - Eligible when any ch_req_i=1 and fifo count < OUTSTD.
  - Winner = first requesting channel at or after the rr pointer, wrapping from N_CH-1 to 0.
  - Latch winner id and ch_addr_i[winner]; go to REQ.
- FSM REQ:
  - l2_req_o=1 and l2_addr_o=latched address, held stable.
  - No re-arbitration while in REQ; ch_req_i changes are ignored.
  - On l2_gnt_i=1: ch_gnt_o[id]=1 in the same cycle (combinational from l2_gnt_i), push id to FIFO, rr pointer=(id+1) mod N_CH, go to IDLE.
- Throughput: at most one grant per 2 cycles; at least one IDLE cycle between grants.
- Latency: first ch_req_i high cycle -> l2_req_o high on next cycle.
- Starvation freedom: with all channels requesting, each channel is granted once per N_CH grants.
- Return path:
  - l2_rvalid_i=1 with FIFO non-empty: ch_rvalid_o[head]=1 and ch_rdata_o=l2_rdata_i in the same cycle (zero latency); pop FIFO.
  - l2_rvalid_i=1 with FIFO empty: no ch_rvalid_o; err_o set; cleared only by rst_i.
- ch_rdata_o = l2_rdata_i always (not gated).
- Simultaneous push and pop: count unchanged; pointers both advance.
- FIFO full (count=OUTSTD): IDLE does not arbitrate. A pop in the same cycle does not unblock that cycle; arbitration resumes on the next cycle.
- Pointer wrap: FIFO rd/wr pointers are log2(OUTSTD) bits and wrap naturally; count is log2(OUTSTD)+1 bits.
- busy_o = (state==REQ) | (count!=0).

Optional Feature:
Macro UDMA_TX_L2_ARB_PRIO0_EN.
- Defined: channel 0 has strict priority. If ch_req_i[0]=1 in IDLE, it wins regardless of the rr pointer; a channel-0 grant does not move the rr pointer. Other channels use round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Single request: rst; ch_req_i=4'b0100, addr 0x1C00_0040; l2_gnt_i one cycle after l2_req_o -> l2_addr_o=0x1C00_0040, ch_gnt_o=4'b0100 in the gnt cycle; l2_rvalid_i, rdata 0xDEAD_BEEF two cycles later -> ch_rvalid_o=4'b0100, ch_rdata_o=0xDEAD_BEEF.
- Round robin: all 4 channels request continuously, l2_gnt_i tied 1, rvalid returned 1 cycle after each grant -> grant order 0,1,2,3,0,1; consecutive grants exactly 2 cycles apart.
- Outstanding limit: OUTSTD=4, l2_gnt_i=1, l2_rvalid_i=0 -> exactly 4 grants, then l2_req_o stays 0 and busy_o=1. One rvalid -> ch_rvalid_o routed to the first granted channel; 5th grant follows.
- Stall: l2_gnt_i=0 for 10 cycles in REQ while ch_req_i toggles -> l2_req_o/l2_addr_o stable; granted channel is the one latched at entry to REQ.
- Error and reset: l2_rvalid_i with empty FIFO -> err_o=1, no ch_rvalid_o. Assert rst_i with 2 reads outstanding -> all outputs 0 next cycle; err_o cleared.
- With UDMA_TX_L2_ARB_PRIO0_EN defined: channels 0 and 2 request continuously -> channel 0 granted every time; channel 2 never granted until ch_req_i[0] drops, then granted on the next arbitration.
